varredura_matriz: RTL
=====================

# varredura_matriz

Scanning driver for the 7-row × 5-column LED dot matrix. It sits directly downstream of the 3-bit map decoder and consumes that decoder's 35-bit pattern. It row-multiplexes the pattern onto the matrix pins, with tear-free frame updates, anti-ghost blanking and an optional blinking cursor dot.

## Interface
- `ROW_PERIOD`, default 50000: clock cycles per row slot, blank cycle included; legal values are ≥ 2.
- `BLINK_FRAMES`, default 16: frames per blink half-period; legal values are ≥ 1.
- `clk`, in, 1: sole clock.
- `reset`, in, 1: asynchronous, active-high.
- `frame`, in, 35: pattern from the map decoder. Bit `5*r + c` is row r (0..6), column c (0..4); 1 = LED on.
- `frame_valid`, in, 1: level; when high at a rising edge, `frame` is captured.
- `cursor_en`, in, 1: enables the blink overlay.
- `cursor_pos`, in, 6: bit index 0..34 to blink; values 35..63 have no effect.
- `row_n`, out, 7: row select, active-low, one-hot or all-ones.
- `col`, out, 5: column data, active-high.
- `frame_done`, out, 1: one-cycle pulse at the start of each frame.

## Operation
- **Registers:**
  - `pending` (35 bits) and `pend_v` (1 bit).
  - `active` (35 bits): the displayed frame.
  - `div` (prescaler, 0..ROW_PERIOD-1) and `row` (0..6).
  - `bcnt` (0..BLINK_FRAMES-1) and `phase` (1 bit).
- **Capture:**
  - `frame_valid` high at an edge sets `pending <= frame` and `pend_v <= 1`.
  - The last write before a frame boundary wins.
- **Row sequencing:**
  - `div` increments every cycle. At `div == ROW_PERIOD-1` it wraps to 0 and `row` advances, wrapping from 6 to 0.
- **Slot output:**
  - Slot `div == 0` is blank: `row_n = 7'b1111111`, `col = 0`.
  - Slots `div ≥ 1`: `row_n = ~(1 << row)`, `col = disp[5*row+4 : 5*row]`.
- **Displayed pattern:** `disp = active ^ (ovl << cursor_pos)`, where `ovl = cursor_en & phase & (cursor_pos < 35)`.
- **Frame boundary** (the edge where `row` wraps from 6 to 0):
  - If `frame_valid` is high on that same edge, `active <= frame` directly; the bypass wins over `pending`.
  - Otherwise, if `pend_v` is set, `active <= pending`.
  - `pend_v` clears in both load cases.
  - `bcnt` increments. On wrap from BLINK_FRAMES-1 to 0, `phase` toggles.
- **Cursor gating:** blink counters run regardless of `cursor_en`; only the overlay is gated. `cursor_en` and `cursor_pos` act combinationally into `disp` and are registered into `col` at the next slot.
- **Reset:**
  - All registers clear.
  - Outputs: `row_n = 7'b1111111`, `col = 5'b0`, `frame_done = 0`.
  - Reset asserted mid-frame blanks the matrix immediately and discards both `pending` and `active`.

## Timing
- All outputs are registered. `row_n`/`col` reflect the `div`/`row` state of the previous cycle.
- **After reset release:**
  - The first edge produces the row-0 blank slot.
  - Row 0 is lit from the output of the 2nd edge onward.
- **Frame period:** 7 × ROW_PERIOD cycles. Each row is lit for ROW_PERIOD-1 cycles.
- **`frame_done`:** high for exactly the cycle of row 0's blank slot in every frame, including the first frame after reset.
- **Update latency:** a captured frame appears on row 0 of the frame that follows the next boundary. It is never shown mid-frame, so there is no tearing.
- **Blink half-period:** BLINK_FRAMES × 7 × ROW_PERIOD cycles.
- **Overlap rule:** two rows are never low in the same cycle. Every row change passes through one all-ones cycle.

## Structure
- **Shared package `matriz_pkg`:**
  - `N_ROWS = 7`, `N_COLS = 5`, `FRAME_W = 35`.
  - `ROW_OFF = 7'b1111111`.
  - Helper function `row_sel(row)` returning the active-low one-hot vector.
- **Sub-module `div_tick`:** a parameterised prescaler emitting a one-cycle `tick` every ROW_PERIOD cycles. The same block is reused for the blink counter, with `tick` as its enable.
- The top holds `pending`/`active`, the row counter, the overlay and the output registers.

## Test plan
All scenarios use ROW_PERIOD = 4 and BLINK_FRAMES = 2 unless stated.
- **Reset and first frame:**
  - Hold reset, then release with `frame = 35'h7_FFFF_FFFF` and `frame_valid = 1` for 1 cycle.
  - During reset: `row_n = 7'h7F`, `col = 0`.
  - `frame_done` pulses at cycle 1. The first frame shows `col = 0`.
  - From the second frame on (cycle 29): `col = 5'h1F` on every lit slot, and rows go 0..6 with one blank cycle between them.
- **Row mapping:**
  - Apply `frame = 35'h1 << 17` (row 3, col 2) and let it load.
  - Only row 3 lit slots show `col = 5'b00100`. All other rows show `col = 0`.
- **Tear-free update:**
  - Pulse `frame_valid` with A = all-ones during row 2, then with B = 0 during row 4.
  - The current frame is unchanged. The next frame shows B (last write wins); A is never displayed.
- **Boundary bypass:**
  - Assert `frame_valid` exactly on the row-6-to-0 wrap edge with `frame = 35'h0_0000_001F`.
  - The frame starting that edge shows `col = 5'h1F` on row 0.
- **Cursor blink:**
  - Set `active = 0`, `cursor_en = 1`, `cursor_pos = 34`.
  - Row 6 shows `col = 5'b10000` during frames 3–4 and `col = 0` during frames 1–2 and 5–6.
  - With `cursor_pos = 40`, `col` stays 0.
- **Reset mid-operation:**
  - Assert reset during row 4 lit.
  - `row_n = 7'h7F` and `col = 0` with no clock edge.
  - After release the display is blank until a new frame loads.

Source files
------------

// File: rtl/matriz_pkg.sv
// Shared constants and helpers for the 7x5 LED matrix scanning driver.
// Row indices are 3-bit; row_sel turns one into the active-low row-select vector.
package matriz_pkg;

   localparam int N_ROWS  = 7;
   localparam int N_COLS  = 5;
   localparam int FRAME_W = 35;

   localparam logic [N_ROWS-1:0] ROW_OFF = 7'b1111111;

   typedef logic [2:0] row_idx_t;

   function automatic logic [N_ROWS-1:0] row_sel(input row_idx_t row);
      return ~(N_ROWS'(1) << row);
   endfunction

endpackage

// File: rtl/div_tick.sv
// Free-running modulo-PERIOD counter advancing while i_en is high.
// o_tick marks the enabled cycle in which the count wraps back to zero.
module div_tick #(
   parameter int PERIOD = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i_en,
   output logic o_tick
);

   localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

   logic [CW-1:0] r_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_en) begin
         if (r_count == LAST) begin
            r_count <= '0;
         end else begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   assign o_tick = i_en && (r_count == LAST);

endmodule

// File: rtl/varredura_matriz.sv
// Row-multiplexed scanning driver for the 7x5 LED matrix, with frame-boundary
// updates, one blank cycle before every row, and an optional blinking cursor dot.
module varredura_matriz
   import matriz_pkg::*;
#(
   parameter int ROW_PERIOD   = 50000,
   parameter int BLINK_FRAMES = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [FRAME_W-1:0] frame,
   input  logic               frame_valid,
   input  logic               cursor_en,
   input  logic [5:0]         cursor_pos,
   output logic [N_ROWS-1:0]  row_n,
   output logic [N_COLS-1:0]  col,
   output logic               frame_done
);

   logic               w_rowTick;
   logic               w_frameTick;
   logic               w_blinkTick;
   logic               w_ovl;
   logic [FRAME_W-1:0] w_disp;
   logic [N_COLS-1:0]  w_rowData;

   logic [FRAME_W-1:0] r_pending;
   logic               r_pendV;
   logic [FRAME_W-1:0] r_active;
   row_idx_t           r_row;
   logic               r_atZero;
   logic               r_phase;
   logic [N_ROWS-1:0]  r_rowN;
   logic [N_COLS-1:0]  r_col;
   logic               r_frameDone;

   div_tick #(.PERIOD(ROW_PERIOD)) u_rowDiv (
      .clk    (clk),
      .reset  (reset),
      .i_en   (1'b1),
      .o_tick (w_rowTick)
   );

   assign w_frameTick = w_rowTick && (r_row == row_idx_t'(N_ROWS - 1));

   div_tick #(.PERIOD(BLINK_FRAMES)) u_blinkDiv (
      .clk    (clk),
      .reset  (reset),
      .i_en   (w_frameTick),
      .o_tick (w_blinkTick)
   );

   assign w_ovl  = cursor_en && r_phase && (cursor_pos < 6'd35);
   assign w_disp = r_active ^ (w_ovl ? (FRAME_W'(1) << cursor_pos) : '0);

   always_comb begin
      w_rowData = '0;
      for (int r = 0; r < N_ROWS; r++) begin
         if (r_row == row_idx_t'(r)) begin
            w_rowData = w_disp[r*N_COLS +: N_COLS];
         end
      end
   end

   // r_atZero mirrors "prescaler is at 0": true out of reset and right after every wrap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_row    <= '0;
         r_atZero <= 1'b1;
         r_phase  <= 1'b0;
      end else begin
         r_atZero <= w_rowTick;
         if (w_rowTick) begin
            r_row <= (r_row == row_idx_t'(N_ROWS - 1)) ? '0 : r_row + 3'd1;
         end
         if (w_blinkTick) begin
            r_phase <= ~r_phase;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pending <= '0;
         r_pendV   <= 1'b0;
         r_active  <= '0;
      end else begin
         if (frame_valid) begin
            r_pending <= frame;
            r_pendV   <= 1'b1;
         end
         if (w_frameTick) begin
            if (frame_valid) begin
               r_active <= frame;
            end else if (r_pendV) begin
               r_active <= r_pending;
            end
            r_pendV <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rowN      <= ROW_OFF;
         r_col       <= '0;
         r_frameDone <= 1'b0;
      end else begin
         r_frameDone <= r_atZero && (r_row == '0);
         if (r_atZero) begin
            r_rowN <= ROW_OFF;
            r_col  <= '0;
         end else begin
            r_rowN <= row_sel(r_row);
            r_col  <= w_rowData;
         end
      end
   end

   assign row_n      = r_rowN;
   assign col        = r_col;
   assign frame_done = r_frameDone;

endmodule
